// File: rtl/io_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Grants are held for up to BURST_LEN beats; every release passes through one IDLE cycle.
module io_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          clr_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_valid_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  input  logic                          fifo_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [LOG_NUM_REQ-1:0]        grant_id_o,
  output logic                          busy_o
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 state;
  logic [LOG_NUM_REQ-1:0] gnt_id;
  logic [LOG_NUM_REQ-1:0] rr_ptr;
  logic [CNT_W-1:0]       beat_cnt;

  logic                   pick_found;
  logic [LOG_NUM_REQ-1:0] pick_id;
  int unsigned            scan_idx;
  logic [LOG_NUM_REQ-1:0] next_ptr;
  logic                   beat;
  logic                   last_beat;
  logic                   release_gnt;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && req_valid_i[LOG_NUM_REQ'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_id    = LOG_NUM_REQ'(scan_idx);
      end
    end
  end

  // Combinational data path from the grantee to the FIFO; reset/clear suppress the beat
  always_comb begin
    grant_o      = '0;
    req_ready_o  = '0;
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    if (state == ST_GRANT) begin
      grant_o[gnt_id]     = 1'b1;
      fifo_valid_o        = req_valid_i[gnt_id] & ~clr_i & rstn_i;
      fifo_data_o         = req_data[gnt_id];
      req_ready_o[gnt_id] = fifo_ready_i & ~clr_i & rstn_i;
    end
  end

  assign grant_id_o  = (state == ST_GRANT) ? gnt_id : '0;
  assign busy_o      = (state == ST_GRANT);
  assign beat        = fifo_valid_o & fifo_ready_i;
  assign last_beat   = beat && (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign release_gnt = last_beat || !req_valid_i[gnt_id];
  assign next_ptr    = (gnt_id == LOG_NUM_REQ'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      state    <= ST_IDLE;
      gnt_id   <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state    <= ST_GRANT;
            gnt_id   <= pick_id;
            beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (release_gnt) begin
            state    <= ST_IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_fifo_wr_arbiter.sv
// Directed bench for io_fifo_wr_arbiter: reset, single-source bursts, rotation,
// backpressure, early valid drop and soft clear.
module tb_io_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic             clr;
  logic [NR-1:0]    valid;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]    req_ready;
  logic             fifo_valid;
  logic [DW-1:0]    fifo_data;
  logic             ready;
  logic [NR-1:0]    grant;
  logic [LW-1:0]    gid;
  logic             busy;

  int cnt [NR];
  int total = 0;
  int bad   = 0;
  int order [5] = '{0, 1, 2, 3, 0};

  io_fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .LOG_NUM_REQ(LW)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .clr_i       (clr),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_ready_o (req_ready),
    .fifo_valid_o(fifo_valid),
    .fifo_data_o (fifo_data),
    .fifo_ready_i(ready),
    .grant_o     (grant),
    .grant_id_o  (gid),
    .busy_o      (busy)
  );

  function automatic logic [31:0] tagv(input int k, input int b);
    return 32'hA500_0000 | (32'(k) << 16) | 32'(b);
  endfunction

  // Requester k presents beat number cnt[k]
  always_comb begin
    for (int k = 0; k < NR; k++) data[k*DW +: DW] = tagv(k, cnt[k]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".gid"}, 32'(gid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".fvalid"}, 32'(fifo_valid), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".fdata"}, fifo_data, 32'd0);
  endtask

  task automatic chk_g(input string tag, input int id, input logic fv, input logic [NR-1:0] rdy);
    #1;
    chk({tag, ".grant"}, 32'(grant), 32'd1 << id);
    chk({tag, ".gid"}, 32'(gid), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".fvalid"}, 32'(fifo_valid), 32'(fv));
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".fdata"}, fifo_data, tagv(id, cnt[id]));
  endtask

  // From IDLE: one arbitration cycle, then n accepted beats, then the IDLE bubble
  task automatic burst(input string tag, input int id, input int n);
    tick();
    for (int b = 0; b < n; b++) begin
      chk_g(tag, id, 1'b1, NR'(1) << id);
      tick();
      cnt[id]++;
    end
    chk_idle({tag, ".bubble"});
  endtask

  initial begin
    for (int k = 0; k < NR; k++) cnt[k] = 0;
    rstn  = 1'b0;
    clr   = 1'b0;
    ready = 1'b1;
    valid = 4'hF;

    // Reset held two cycles with every requester valid
    tick();
    chk_idle("rst0");
    tick();
    chk_idle("rst1");
    rstn = 1'b1;
    chk_idle("rst_rel");
    tick();
    chk_g("t1_gnt0", 0, 1'b1, 4'b0001);
    valid = 4'h0;
    chk_g("t1_drop", 0, 1'b0, 4'b0001);
    tick();
    chk_idle("t1_idle");

    // Requester 2 alone, 6 beats: full burst, bubble, then 2 more beats
    valid = 4'b0100;
    chk_idle("t2_arb");
    burst("t2_b1", 2, 4);
    tick();
    for (int b = 0; b < 2; b++) begin
      chk_g("t2_b2", 2, 1'b1, 4'b0100);
      tick();
      cnt[2]++;
    end
    valid = 4'h0;
    chk_g("t2_drop", 2, 1'b0, 4'b0100);
    tick();
    chk_idle("t2_end");

    // Clear rr_ptr, then all four valid: order 0,1,2,3,0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    valid = 4'hF;
    chk_idle("t3_arb");
    for (int i = 0; i < 5; i++) burst($sformatf("t3_rr%0d", i), order[i], 4);

    // Backpressure after beat 1 on requester 1
    valid = 4'b0010;
    tick();
    for (int b = 0; b < 2; b++) begin
      chk_g("t4_pre", 1, 1'b1, 4'b0010);
      tick();
      cnt[1]++;
    end
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_g("t4_stall", 1, 1'b1, 4'b0000);
      tick();
    end
    ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      chk_g("t4_post", 1, 1'b1, 4'b0010);
      tick();
      cnt[1]++;
    end
    chk_idle("t4_end");

    // Requester 1 drops valid after 2 beats while 3 waits; rr_ptr becomes 2
    tick();
    chk_g("t5_gnt1", 1, 1'b1, 4'b0010);
    valid = 4'b1010;
    for (int b = 0; b < 2; b++) begin
      chk_g("t5_beat", 1, 1'b1, 4'b0010);
      tick();
      cnt[1]++;
    end
    valid = 4'b1000;
    chk_g("t5_drop", 1, 1'b0, 4'b0010);
    tick();
    valid = 4'b1001;
    chk_idle("t5_bubble");
    tick();

    // Soft clear on requester 3's third beat
    for (int b = 0; b < 2; b++) begin
      chk_g("t6_beat", 3, 1'b1, 4'b1000);
      tick();
      cnt[3]++;
    end
    clr = 1'b1;
    chk_g("t6_clr", 3, 1'b0, 4'b0000);
    tick();
    clr = 1'b0;
    valid = 4'hF;
    chk_idle("t6_idle");
    tick();
    chk_g("t6_gnt0", 0, 1'b1, 4'b0001);
    valid = 4'h0;
    tick();
    chk_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
